// File: rtl/fwd_ctrl_unit_pkg.sv
// ============================================================================
// Module   : fwd_ctrl_unit_pkg
// Brief    : Shared constants and stage-record type for EX-stage forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fwd_ctrl_unit_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int SEL_W      = 2;

    localparam logic [SEL_W-1:0] FWD_SEL_REGFILE = 2'b00;
    localparam logic [SEL_W-1:0] FWD_SEL_EXMEM   = 2'b01;
    localparam logic [SEL_W-1:0] FWD_SEL_MEMWB   = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  we;
        logic                  is_load;
    } stage_rec_t;

    localparam stage_rec_t STAGE_BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/fwd_ctrl_unit_fwd_src_cmp.sv
// ============================================================================
// Module   : fwd_src_cmp
// Brief    : Picks the forwarding source for one operand from two producers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_src_cmp
    import fwd_ctrl_unit_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  en,
    input  stage_rec_t            younger,
    input  stage_rec_t            older,
    output logic [SEL_W-1:0]      sel
);

    logic w_hit_young;
    logic w_hit_old;
    logic w_unused;

    // Bubbles carry we=0, so the write-enable alone qualifies a producer.
    assign w_hit_young = younger.we && (younger.dest != '0) && (younger.dest == src);
    assign w_hit_old   = older.we   && (older.dest   != '0) && (older.dest   == src);

    always_comb begin
        sel = FWD_SEL_REGFILE;
        if (en) begin
            if (w_hit_young) begin
                sel = FWD_SEL_EXMEM;
            end else if (w_hit_old) begin
                sel = FWD_SEL_MEMWB;
            end
        end
    end

    assign w_unused = ^{younger.valid, younger.is_load, older.valid, older.is_load};

endmodule

`default_nettype wire

// File: rtl/fwd_ctrl_unit.sv
// ============================================================================
// Module   : fwd_ctrl_unit
// Brief    : EX-stage operand forwarding selects and load-use stall control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_ctrl_unit
    import fwd_ctrl_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_we,
    input  logic                  id_is_load,
    input  logic                  flush,
    output logic                  stall,
    output logic [SEL_W-1:0]      fwd_a_sel,
    output logic [SEL_W-1:0]      fwd_b_sel,
    output logic                  ex_valid
);

    stage_rec_t       r_ex;
    stage_rec_t       r_mem;
    stage_rec_t       r_wb;
    logic             w_bubble;
    logic [SEL_W-1:0] w_sel_a;
    logic [SEL_W-1:0] w_sel_b;
    logic             w_unused_wb;

    assign stall = id_valid & r_ex.valid & r_ex.is_load & r_ex.we & (r_ex.dest != '0)
                 & ((r_ex.dest == id_rs) | (id_uses_rt & (r_ex.dest == id_rt)));

    assign w_bubble = flush | stall | ~id_valid;

    // The ID instruction's producers are the current EX (next MEM) and MEM (next WB).
    fwd_src_cmp u_cmp_a (
        .src     (id_rs),
        .en      (1'b1),
        .younger (r_ex),
        .older   (r_mem),
        .sel     (w_sel_a)
    );

    fwd_src_cmp u_cmp_b (
        .src     (id_rt),
        .en      (id_uses_rt),
        .younger (r_ex),
        .older   (r_mem),
        .sel     (w_sel_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex      <= STAGE_BUBBLE;
            r_mem     <= STAGE_BUBBLE;
            r_wb      <= STAGE_BUBBLE;
            fwd_a_sel <= FWD_SEL_REGFILE;
            fwd_b_sel <= FWD_SEL_REGFILE;
        end else begin
            r_mem <= r_ex;
            r_wb  <= r_mem;
            if (w_bubble) begin
                r_ex      <= STAGE_BUBBLE;
                fwd_a_sel <= FWD_SEL_REGFILE;
                fwd_b_sel <= FWD_SEL_REGFILE;
            end else begin
                r_ex      <= '{valid: 1'b1, dest: id_rd, we: id_we, is_load: id_is_load};
                fwd_a_sel <= w_sel_a;
                fwd_b_sel <= w_sel_b;
            end
        end
    end

    assign ex_valid = r_ex.valid;

    // WB is tracked for completeness; the write-before-read regfile covers that hazard.
    assign w_unused_wb = ^r_wb;

endmodule

`default_nettype wire

// File: tb/tb_fwd_ctrl_unit.sv
// ============================================================================
// Module   : tb_fwd_ctrl_unit
// Brief    : Directed cycle-by-cycle vector bench for fwd_ctrl_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fwd_ctrl_unit;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] id_rd;
    logic       id_we;
    logic       id_is_load;
    logic       flush;
    logic       stall;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       ex_valid;

    int n_checks = 0;
    int n_fail   = 0;

    fwd_ctrl_unit dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .id_rd      (id_rd),
        .id_we      (id_we),
        .id_is_load (id_is_load),
        .flush      (flush),
        .stall      (stall),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel),
        .ex_valid   (ex_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       fl;
        logic       exp_stall;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
        logic       exp_exv;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic v, input int rs, input int rt, input logic urt,
                                input int rd, input logic we, input logic ld, input logic fl,
                                input logic es, input logic [1:0] ea, input logic [1:0] eb,
                                input logic ev);
        vec_t t;
        t.valid = v;  t.rs = rs[4:0]; t.rt = rt[4:0]; t.urt = urt;
        t.rd = rd[4:0]; t.we = we; t.ld = ld; t.fl = fl;
        t.exp_stall = es; t.exp_a = ea; t.exp_b = eb; t.exp_exv = ev;
        return t;
    endfunction

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid   = v.valid;
        id_rs      = v.rs;
        id_rt      = v.rt;
        id_uses_rt = v.urt;
        id_rd      = v.rd;
        id_we      = v.we;
        id_is_load = v.ld;
        flush      = v.fl;
    endtask

    // stall is sampled mid-cycle; selects/ex_valid just after the edge that loads EX.
    task automatic step(input vec_t v, input string tag);
        drive(v);
        @(negedge clk);
        chk({tag, " stall"}, {1'b0, stall}, {1'b0, v.exp_stall});
        @(posedge clk);
        #1;
        chk({tag, " fwd_a_sel"}, fwd_a_sel, v.exp_a);
        chk({tag, " fwd_b_sel"}, fwd_b_sel, v.exp_b);
        chk({tag, " ex_valid"}, {1'b0, ex_valid}, {1'b0, v.exp_exv});
    endtask

    initial begin
        //              v  rs  rt urt rd we ld fl  stall a      b      exv
        vecs[0]  = mk(1,  1,  2, 1,  3, 1, 0, 0,  0, 2'b00, 2'b00, 1); // r3 <= r1+r2
        vecs[1]  = mk(1,  3,  5, 1,  4, 1, 0, 0,  0, 2'b01, 2'b00, 1); // r4 <= r3+r5
        vecs[2]  = mk(1,  9, 10, 1,  8, 1, 0, 0,  0, 2'b00, 2'b00, 1);
        vecs[3]  = mk(1,  1,  2, 1,  3, 1, 0, 0,  0, 2'b00, 2'b00, 1); // producer r3
        vecs[4]  = mk(1,  1,  2, 1,  9, 1, 0, 0,  0, 2'b00, 2'b00, 1); // unrelated
        vecs[5]  = mk(1,  3,  7, 1, 10, 1, 0, 0,  0, 2'b10, 2'b00, 1); // consumer r3 via MEM
        vecs[6]  = mk(1,  1,  6, 0,  6, 1, 1, 0,  0, 2'b00, 2'b00, 1); // lw r6
        vecs[7]  = mk(1,  6,  6, 1,  7, 1, 0, 0,  1, 2'b00, 2'b00, 0); // load-use stall
        vecs[8]  = mk(1,  6,  6, 1,  7, 1, 0, 0,  0, 2'b10, 2'b10, 1); // replay after bubble
        vecs[9]  = mk(1,  1,  2, 1,  5, 1, 0, 0,  0, 2'b00, 2'b00, 1); // r5 writer 1
        vecs[10] = mk(1,  1,  2, 1,  5, 1, 0, 0,  0, 2'b00, 2'b00, 1); // r5 writer 2
        vecs[11] = mk(1,  5,  5, 0, 11, 1, 0, 0,  0, 2'b01, 2'b00, 1); // youngest wins, rt unused
        vecs[12] = mk(1,  1,  2, 1,  0, 1, 0, 0,  0, 2'b00, 2'b00, 1); // writes r0
        vecs[13] = mk(1,  0,  0, 1, 12, 1, 0, 0,  0, 2'b00, 2'b00, 1); // reads r0
        vecs[14] = mk(1,  1,  0, 0,  0, 1, 1, 0,  0, 2'b00, 2'b00, 1); // lw r0
        vecs[15] = mk(1,  0,  0, 1, 13, 1, 0, 0,  0, 2'b00, 2'b00, 1); // use r0, no stall
        vecs[16] = mk(1,  1, 14, 0, 14, 1, 1, 0,  0, 2'b00, 2'b00, 1); // lw r14
        vecs[17] = mk(1, 14,  2, 1, 15, 1, 0, 1,  1, 2'b00, 2'b00, 0); // flush + load-use
        vecs[18] = mk(1,  1,  2, 1, 16, 1, 0, 0,  0, 2'b00, 2'b00, 1); // producer r16
        vecs[19] = mk(1, 16, 16, 1, 17, 1, 0, 1,  0, 2'b00, 2'b00, 0); // flush drops forward
        vecs[20] = mk(0, 16, 16, 1, 17, 1, 0, 0,  0, 2'b00, 2'b00, 0); // empty ID slot
        vecs[21] = mk(1, 16, 16, 1, 18, 1, 0, 0,  0, 2'b00, 2'b00, 1); // r16 now in WB only
        vecs[22] = mk(1,  1, 19, 0, 19, 1, 1, 0,  0, 2'b00, 2'b00, 1); // lw r19
        vecs[23] = mk(1,  2, 19, 1, 20, 1, 0, 0,  1, 2'b00, 2'b00, 0); // stall via rt
        vecs[24] = mk(1,  2, 19, 1, 20, 1, 0, 0,  0, 2'b00, 2'b10, 1);
        vecs[25] = mk(1,  1, 21, 0, 21, 1, 1, 0,  0, 2'b00, 2'b00, 1); // lw r21
        vecs[26] = mk(1,  3, 21, 0, 22, 1, 0, 0,  0, 2'b00, 2'b00, 1); // rt match, rt unused

        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        #1;
        chk("reset fwd_a_sel", fwd_a_sel, 2'b00);
        chk("reset fwd_b_sel", fwd_b_sel, 2'b00);
        chk("reset ex_valid", {1'b0, ex_valid}, 2'b00);
        chk("reset stall", {1'b0, stall}, 2'b00);
        #11;
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of a load-use hazard.
        step(mk(1,  1,  2, 1, 25, 1, 0, 0, 0, 2'b00, 2'b00, 1), "pre-rst producer");
        step(mk(1, 25, 26, 0, 26, 1, 1, 0, 0, 2'b01, 2'b00, 1), "pre-rst lw");
        drive(mk(1, 26, 1, 1, 27, 1, 0, 0, 0, 2'b00, 2'b00, 0));
        #1;
        chk("pre-rst stall", {1'b0, stall}, 2'b01);
        rst = 1'b1;
        #1;
        chk("mid-rst stall", {1'b0, stall}, 2'b00);
        chk("mid-rst fwd_a_sel", fwd_a_sel, 2'b00);
        chk("mid-rst fwd_b_sel", fwd_b_sel, 2'b00);
        chk("mid-rst ex_valid", {1'b0, ex_valid}, 2'b00);
        @(negedge clk);
        #2;
        rst = 1'b0;

        step(mk(1, 26,  1, 1, 27, 1, 0, 0, 0, 2'b00, 2'b00, 1), "post-rst first");
        step(mk(1,  1,  2, 1, 24, 1, 0, 0, 0, 2'b00, 2'b00, 1), "post-rst producer");
        step(mk(1, 24, 24, 1, 28, 1, 0, 0, 0, 2'b01, 2'b01, 1), "post-rst consumer");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fwd_ctrl_unit.md
Name: fwd_ctrl_unit

Overview:
- Generates the 2-bit select codes for the two 3:1 ALU-operand forwarding muxes in the EX stage of the 5-stage pipelined CPU.
- Internally tracks the destination and write-enable of the instructions in EX, MEM and WB.
- Detects load-use hazards, asserts a stall, and inserts a bubble.
- It is the control end of the forwarding datapath: the muxes consume the selects this block produces.

Parameters:
REG_ADDR_W, 5, register-address width (32 GPRs, r0 hardwired zero)
SEL_W, 2, forwarding-select width

Ports:
clk  input  1  pipeline clock, rising-edge
rst  input  1  asynchronous, active-high reset
id_valid  input  1  ID stage holds a real instruction
id_rs  input  REG_ADDR_W  source register A of ID instruction
id_rt  input  REG_ADDR_W  source register B of ID instruction
id_uses_rt  input  1  ID instruction reads rt as an operand (0 for I-type ALU/load)
id_rd  input  REG_ADDR_W  destination register of ID instruction
id_we  input  1  ID instruction writes the register file
id_is_load  input  1  ID instruction is a load (result available only after MEM)
flush  input  1  squash the ID instruction (branch taken)
stall  output  1  hold PC and IF/ID this cycle (combinational)
fwd_a_sel  output  SEL_W  operand-A mux select for the instruction now in EX
fwd_b_sel  output  SEL_W  operand-B mux select for the instruction now in EX
ex_valid  output  1  EX stage holds a real (non-bubble) instruction

Behaviour:
- Select encoding: 00 = register-file operand, 01 = EX/MEM ALU result, 10 = MEM/WB writeback value. 11 is never driven.
- Internal per-stage records for EX, MEM and WB: {valid, dest, we, is_load}. Invalid or bubble records have we=0.
- Reset (async, rst=1):
  - All records cleared: valid=0, we=0, dest=0.
  - fwd_a_sel=00, fwd_b_sel=00, ex_valid=0.
  - stall reads 0 while rst is high.
- Stall (combinational): stall = id_valid & EX.valid & EX.is_load & EX.we & (EX.dest!=0) & ((EX.dest==id_rs) | (id_uses_rt & EX.dest==id_rt)).
- Each rising edge, the records shift: WB<=MEM, MEM<=EX.
  - EX<=bubble if stall | flush | !id_valid.
  - Otherwise EX<={1, id_rd, id_we, id_is_load}.
  - flush has priority over stall; both produce the same bubble.
- Select registers are updated on the same edge, from pre-edge state. The EX instruction becomes MEM and the MEM instruction becomes WB:
  - fwd_a_sel <= 01 if EX.we & EX.dest!=0 & EX.dest==id_rs.
  - Else 10 if MEM.we & MEM.dest!=0 & MEM.dest==id_rs.
  - Else 00.
  - fwd_b_sel follows the same rule on id_rt, gated by id_uses_rt (00 when id_uses_rt=0).
  - When EX receives a bubble, both selects <= 00.
- Priority: the younger producer (01) beats the older (10) when both match.
- Latency: selects are valid for the full EX cycle, one cycle after the instruction leaves ID.
- A load in EX is never forwarded via 01. The stall guarantees the consumer reaches EX only when the load is in WB, which gives select 10.
- WB-to-ID hazard is not forwarded here: the register file is write-before-read.
- Destination r0 never triggers a forward or a stall.
- A mid-operation reset drops all in-flight records immediately; the first post-reset instruction sees 00/00.

Decomposition:
- Shared package holds:
  - FWD_SEL_REGFILE=2'b00, FWD_SEL_EXMEM=2'b01, FWD_SEL_MEMWB=2'b10.
  - REG_ADDR_W.
  - The stage-record struct {valid, dest, we, is_load}.
- One natural sub-module, fwd_src_cmp: a purely combinational comparator taking one source register, two stage records and an enable, returning a select code. It is instantiated twice (A, B).

Test Plan:
- ALU r3<=r1+r2, then next cycle r4<=r3+r5 -> second instruction in EX sees fwd_a_sel=01, fwd_b_sel=00, stall=0.
- Producer of r3, one unrelated instruction, then consumer rs=r3 -> consumer in EX sees fwd_a_sel=10.
- lw r6 in EX, ID add r7<=r6+r6 (id_uses_rt=1):
  - stall=1 for exactly one cycle; the next EX is a bubble (ex_valid=0, sels 00).
  - The consumer then enters EX with fwd_a_sel=10, fwd_b_sel=10.
- Back-to-back writers of r5 (EX and MEM), then a consumer of r5 -> fwd_a_sel=01 (youngest wins).
- Producer writes r0, consumer reads r0 -> sels 00, stall=0. Load to r0 followed by a use of r0 -> stall=0.
- flush with a hazard present -> EX bubble, sels 00.
- rst asserted mid-stream (async, between edges) -> outputs 00/00, ex_valid=0 immediately.
- After rst release, a producer/consumer pair forwards normally (01).
